// File: rtl/hk_spi_pkg.sv
// Shared definitions for the housekeeping SPI initiator: command bytes,
// FSM state and byte-phase encodings, and the latched request record.
package hk_spi_pkg;

  localparam logic [7:0] HK_CMD_WR   = 8'h80;
  localparam logic [7:0] HK_CMD_RD   = 8'h40;
  localparam logic [7:0] HK_CMD_RDWR = 8'hC0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    STALL = 3'd3,
    HOLD  = 3'd4
  } hk_state_e;

  typedef enum logic [1:0] {
    PH_CMD  = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2
  } hk_phase_e;

  typedef struct packed {
    logic       wr;
    logic       rdwr;
    logic [7:0] addr;
  } hk_req_t;

  // Simultaneous read/write wins over plain write.
  function automatic logic [7:0] hk_cmd(input logic wr, input logic rdwr);
    if (rdwr)    return HK_CMD_RDWR;
    else if (wr) return HK_CMD_WR;
    else         return HK_CMD_RD;
  endfunction

endpackage

// File: rtl/hk_spi_clkgen.sv
// SCK half-period generator: counts 0..div, strobes tick at each half-period
// end and toggles SCK when enabled for shifting.
module hk_spi_clkgen
  #(parameter int DIV_W = 8)
  (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             sck_en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             rise_tick_o,
    output logic             fall_tick_o,
    output logic             sck_o
  );

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;

  assign tick_o      = en_i & ~clr_i & (cnt_q == div_i);
  assign rise_tick_o = tick_o & sck_en_i & ~sck_q;
  assign fall_tick_o = tick_o & sck_en_i & sck_q;
  assign sck_o       = sck_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (tick_o) begin
      cnt_q <= '0;
      if (sck_en_i) sck_q <= ~sck_q;
    end else if (en_i) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/hk_spi_mst.sv
// Housekeeping SPI initiator: cmd byte, addr byte, then len+1 data bytes,
// mode 0, MSB first. Define HK_SPI_MST_RDWR_EN for the 0xC0 read/write command.
module hk_spi_mst
  import hk_spi_pkg::*;
  #(parameter int DIV_W    = 8,
    parameter int LEN_W    = 4,
    parameter int CSB_HOLD = 2)
  (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_wr_i,
`ifdef HK_SPI_MST_RDWR_EN
    input  logic             req_rdwr_i,
`endif
    input  logic [7:0]       req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             wdata_valid_i,
    input  logic [7:0]       wdata_i,
    output logic             wdata_ready_o,
    output logic             rdata_valid_o,
    output logic [7:0]       rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_csb_o,
    output logic             spi_sck_o,
    output logic             spi_sdo_o,
    input  logic             spi_sdi_i
  );

  localparam int HW = (CSB_HOLD > 1) ? $clog2(CSB_HOLD) : 1;

  hk_state_e        state_q, state_d;
  hk_phase_e        phase_q;
  hk_req_t          req_q;
  logic [LEN_W-1:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       sh_q, in_q, rdata_q;
  logic             sdo_q, rvalid_q;
  logic [2:0]       bit_q;
  logic [LEN_W:0]   byte_q;
  logic [HW-1:0]    hold_q;

  logic rdwr_in;
  logic cg_en, cg_clr, cg_sck_en, tick, rise_tick, fall_tick;
  logic accept, byte_end, last_byte, next_data, need_wb, need_rz, hold_end;
  logic wr_any, rd_any;

`ifdef HK_SPI_MST_RDWR_EN
  assign rdwr_in = req_rdwr_i;
`else
  assign rdwr_in = 1'b0;
`endif

  hk_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (cg_en),
    .clr_i       (cg_clr),
    .sck_en_i    (cg_sck_en),
    .div_i       (div_q),
    .tick_o      (tick),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick),
    .sck_o       (spi_sck_o)
  );

  assign wr_any    = req_q.wr | req_q.rdwr;
  assign rd_any    = ~req_q.wr | req_q.rdwr;
  assign accept    = (state_q == IDLE) & req_valid_i;
  assign byte_end  = (state_q == SHIFT) & fall_tick & (bit_q == 3'd7);
  assign last_byte = (phase_q == PH_DATA) & (byte_q == {1'b0, len_q});
  // A fresh data byte is needed after the address and after every non-final data byte.
  assign next_data = byte_end & ((phase_q == PH_ADDR) | ((phase_q == PH_DATA) & ~last_byte));
  assign need_wb   = next_data & wr_any;
  assign need_rz   = next_data & ~wr_any;
  assign hold_end  = (state_q == HOLD) & tick & (hold_q == HW'(CSB_HOLD - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid_i) state_d = SETUP;
      SETUP: if (tick)        state_d = SHIFT;
      SHIFT: begin
        if (byte_end) begin
          if (last_byte)                       state_d = HOLD;
          else if (need_wb && !wdata_valid_i)  state_d = STALL;
        end
      end
      STALL: if (wdata_valid_i) state_d = SHIFT;
      HOLD:  if (hold_end)      state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Outputs and clock-generator control
  always_comb begin
    req_ready_o   = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    done_o        = hold_end;
    spi_csb_o     = (state_q == IDLE) | (state_q == HOLD);
    wdata_ready_o = wdata_valid_i & (need_wb | (state_q == STALL));
    cg_en         = (state_q == SETUP) | (state_q == SHIFT) | (state_q == HOLD);
    cg_clr        = (state_q == IDLE) | (state_q == STALL);
    cg_sck_en     = (state_q == SHIFT);
  end

  // Datapath: later assignments in this block take precedence.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phase_q  <= PH_CMD;
      req_q    <= '0;
      len_q    <= '0;
      div_q    <= '0;
      sh_q     <= '0;
      in_q     <= '0;
      sdo_q    <= 1'b0;
      bit_q    <= '0;
      byte_q   <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept) begin
        req_q   <= '{wr: req_wr_i, rdwr: rdwr_in, addr: req_addr_i};
        len_q   <= req_len_i;
        div_q   <= div_i;
        sh_q    <= hk_cmd(req_wr_i, rdwr_in);
        sdo_q   <= hk_cmd(req_wr_i, rdwr_in) >> 7;
        phase_q <= PH_CMD;
        bit_q   <= '0;
        byte_q  <= '0;
        hold_q  <= '0;
      end
      if ((state_q == SHIFT) && rise_tick)
        in_q <= {in_q[6:0], spi_sdi_i};
      if ((state_q == SHIFT) && fall_tick) begin
        bit_q <= bit_q + 3'd1;
        if (bit_q != 3'd7) begin
          sh_q  <= {sh_q[6:0], 1'b0};
          sdo_q <= sh_q[6];
        end else begin
          case (phase_q)
            PH_CMD: begin
              sh_q    <= req_q.addr;
              sdo_q   <= req_q.addr[7];
              phase_q <= PH_ADDR;
            end
            PH_ADDR: phase_q <= PH_DATA;
            default: begin
              if (rd_any) begin
                rdata_q  <= in_q;
                rvalid_q <= 1'b1;
              end
              if (!last_byte) byte_q <= byte_q + (LEN_W+1)'(1);
            end
          endcase
        end
      end
      if (need_rz) begin
        sh_q  <= 8'h00;
        sdo_q <= 1'b0;
      end
      // Without a write byte, STALL keeps sdo at its last driven bit.
      if (wdata_ready_o) begin
        sh_q  <= wdata_i;
        sdo_q <= wdata_i[7];
      end
      if ((state_q == HOLD) && tick)
        hold_q <= hold_q + HW'(1);
    end
  end

  assign spi_sdo_o     = sdo_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

endmodule
